// File: rtl/fmdll_div_counter.sv
// fmdll_div_counter: N-cycle / M-frame counters and divided clocks for the
// FMDLL path-select mux. The shadow ratios reload only on a frame wrap or on
// a realign request (Sel==01) from the select logic. Illegal Sel codes (11)
// latch a sticky error flag.
module fmdll_div_counter #(
  parameter int NW = 4,
  parameter int MW = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [NW-1:0] N,
  input  logic [MW-1:0] M,
  input  logic [1:0]    Sel,
  output logic [NW-1:0] N_counter,
  output logic [MW-1:0] M_counter,
  output logic          DIV_N,
  output logic          DIV_M,
  output logic          FRAME,
  output logic          ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [NW-1:0] n_cnt_reg, n_cnt_next;
  logic [MW-1:0] m_cnt_reg, m_cnt_next;
  logic [NW-1:0] n_s_reg, n_s_next;
  logic [MW-1:0] m_s_reg, m_s_next;
  logic          div_n_reg, div_n_next;
  logic          div_m_reg, div_m_next;
  logic          frame_reg, frame_next;
  logic          err_reg, err_next;

  // High when the next cycle is a counting cycle (outputs are live).
  logic          active_next;
  // Last cycle of the current frame.
  logic          wrap;
  // Half points use one extra bit so N_s/M_s at full scale cannot overflow.
  logic [NW:0]   hn_next;
  logic [MW:0]   hm_next;

  assign wrap = (n_cnt_reg == n_s_reg) && (m_cnt_reg == m_s_reg);

  // Next-state, counter and shadow update logic.
  always_comb begin
    state_next  = state_reg;
    n_cnt_next  = '0;
    m_cnt_next  = '0;
    n_s_next    = n_s_reg;
    m_s_next    = m_s_reg;
    active_next = 1'b0;
    err_next    = err_reg | (Sel == 2'b11);

    case (state_reg)
      IDLE: begin
        if (EN) begin
          state_next = ALIGN;
        end
      end
      ALIGN: begin
        if (!EN) begin
          state_next = IDLE;
        end else begin
          state_next  = RUN;
          n_s_next    = N;
          m_s_next    = M;
          active_next = 1'b1;
        end
      end
      RUN: begin
        if (!EN) begin
          state_next = IDLE;
        end else begin
          active_next = 1'b1;
          if ((Sel == 2'b01) || wrap) begin
            // Realign or frame wrap: restart from zero with fresh ratios.
            n_s_next = N;
            m_s_next = M;
          end else if (n_cnt_reg == n_s_reg) begin
            m_cnt_next = m_cnt_reg + 1'b1;
          end else begin
            n_cnt_next = n_cnt_reg + 1'b1;
            m_cnt_next = m_cnt_reg;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Divided clocks and frame marker derived from next-state counters so they
  // line up with the registered counter outputs.
  always_comb begin
    hn_next    = ({1'b0, n_s_next} + (NW+1)'(2)) >> 1;
    hm_next    = ({1'b0, m_s_next} + (MW+1)'(2)) >> 1;
    div_n_next = active_next && ({1'b0, n_cnt_next} < hn_next);
    div_m_next = active_next && ({1'b0, m_cnt_next} < hm_next);
    frame_next = active_next && (n_cnt_next == n_s_next)
                             && (m_cnt_next == m_s_next);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      n_cnt_reg <= '0;
      m_cnt_reg <= '0;
      n_s_reg   <= '0;
      m_s_reg   <= '0;
      div_n_reg <= 1'b0;
      div_m_reg <= 1'b0;
      frame_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      n_cnt_reg <= n_cnt_next;
      m_cnt_reg <= m_cnt_next;
      n_s_reg   <= n_s_next;
      m_s_reg   <= m_s_next;
      div_n_reg <= div_n_next;
      div_m_reg <= div_m_next;
      frame_reg <= frame_next;
      err_reg   <= err_next;
    end
  end

  assign N_counter = n_cnt_reg;
  assign M_counter = m_cnt_reg;
  assign DIV_N     = div_n_reg;
  assign DIV_M     = div_m_reg;
  assign FRAME     = frame_reg;
  assign ERR       = err_reg;

endmodule

// File: doc/fmdll_div_counter.md
Name: fmdll_div_counter

Overview:
Generates the N-cycle and M-frame counters and the divided clocks DIV_N and DIV_M for the FMDLL path-select mux. It feeds the select logic, and the select logic's Sel output comes back into it to re-align the counters on each injection. It holds shadow copies of N and M so the division ratios change only on frame boundaries. It also reports frame boundaries and illegal Sel codes.

Parameters:
NW, 4, width of N and N_counter.
MW, 2, width of M and M_counter.

Ports:
CLK  input  1  output-clock domain clock; all state updates on the rising edge.
RST  input  1  reset, synchronous, active-high.
EN  input  1  run enable.
N  input  NW  N ratio; the N period is N+1 CLK cycles.
M  input  MW  M ratio; the frame is M+1 N periods.
Sel  input  2  path select returned by the select logic.
N_counter  output  NW  current position in the N period (registered).
M_counter  output  MW  current N period within the frame (registered).
DIV_N  output  1  divided-by-(N+1) clock (registered).
DIV_M  output  1  divided-by-(M+1) frame clock (registered).
FRAME  output  1  high in the last cycle of a frame (registered).
ERR  output  1  sticky flag: illegal Sel seen.

Behaviour:
- Reset (RST=1 on an edge): state=IDLE; N_counter=0, M_counter=0, DIV_N=0, DIV_M=0, FRAME=0, ERR=0; N_s=0, M_s=0.
- States are IDLE, ALIGN and RUN. RST has priority over all transitions, including mid-frame.
- IDLE:
  - Counters and all outputs are held at 0.
  - When EN=1, go to ALIGN.
- ALIGN (one cycle):
  - Load N_s<=N and M_s<=M.
  - N_counter<=0 and M_counter<=0.
  - DIV_N<=1 and DIV_M<=1. These are the first RUN-cycle values, because counter 0 is always inside the high half.
  - Next state is RUN.
- RUN counting, per cycle:
  - If N_counter==N_s: N_counter<=0. Then, if M_counter==M_s, M_counter<=0 and N_s/M_s reload from N/M (frame wrap); otherwise M_counter<=M_counter+1.
  - Otherwise N_counter<=N_counter+1.
- Half points: HN=(N_s+2)>>1 and HM=(M_s+2)>>1.
  - Compute them at NW+1 and MW+1 bits, so there is no overflow.
  - When the shadows reload on a frame wrap, the next-cycle HN/HM use the newly loaded values.
- Divided clocks are registered from the next-state counters, so they are cycle-aligned with the counter outputs:
  - DIV_N = (next N_counter < HN).
  - DIV_M = (next M_counter < HM).
  - N=0 gives DIV_N constant 1; M=0 gives DIV_M constant 1.
- FRAME is registered high exactly in the cycle where N_counter==N_s and M_counter==M_s.
- Sel handling in RUN:
  - Sel==2'b01 (injection/realign): the next cycle is ALIGN-equivalent. Counters go to 0, shadows reload and DIV_N=DIV_M=1. The state stays RUN.
  - Sel==2'b00 or 2'b10: no effect.
  - Sel==2'b11: ERR<=1 (sticky until RST). Counting continues.
  - In IDLE and ALIGN, Sel is ignored except that 2'b11 still sets ERR.
- EN deasserted while in RUN or ALIGN: the next state is IDLE and all counters and outputs clear to 0 on that edge. ERR is retained.
- Simultaneous events:
  - Sel==01 on the frame-wrap cycle: the realign wins, but the result is the same (counters 0, shadows reload).
  - EN=0 together with Sel==01: go to IDLE.
  - EN=0 together with Sel==11: go to IDLE and set ERR.
- N/M changes mid-frame have no effect until the next frame wrap or realign.
- Latency:
  - EN rise to first ALIGN cycle: 1 edge.
  - Sel==01 to counters at 0: 1 edge.

Test Plan:
- Reset, then EN=1 with N=3, M=1: N_counter sequence 0,1,2,3,0,…; DIV_N 1,1,0,0 repeating; M_counter toggles every 4 cycles; DIV_M=1 while M_counter=0; FRAME pulses once every 8 cycles, at N_counter=3, M_counter=1.
- N=4, M=2 (odd period 5): DIV_N high 3 cycles and low 2; DIV_M high for M_counter 0,1 and low for 2; frame length 15 cycles.
- Change N from 3 to 7 at mid-frame: the old period of 4 continues until FRAME; the first period after the wrap is 8 cycles with HN=4.
- In RUN at N_counter=2, M_counter=1, drive Sel=01 for one cycle: next cycle N_counter=0, M_counter=0, DIV_N=1, DIV_M=1, and counting resumes.
- Drive Sel=11 for one cycle: ERR=1 from the next cycle, stays 1 after EN toggles, and clears only on RST=1.
- N=0, M=0: DIV_N and DIV_M are constant 1 and FRAME=1 every cycle. Assert RST mid-run: all outputs are 0 on the next cycle.
